fft_peak_detector: RTL and testbench

//  Sink for the 256-point FFT output stream. Computes |X[k]|^2 for each bin,

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_bin_power.sv | 70 +++++++
 rtl/fft_peak_detector.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_peak_detector.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT peak detector slice.
// Build option: SPECTRUM_AVG_EN enables per-bin IIR spectrum averaging.
package fft_pkg;

    localparam int FFT_POINTS      = 256;
    localparam int BIN_DATA_WIDTH  = 24;
    localparam int BIN_POWER_WIDTH = 32;
    localparam int BIN_IDX_WIDTH   = $clog2(FFT_POINTS);

    typedef logic [BIN_IDX_WIDTH-1:0] bin_idx_t;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_FLUSH,
        ST_REPORT
    } peak_state_t;

endpackage

// File: rtl/fft_bin_power.sv
// Two-stage pipelined |X|^2 = re^2 + im^2 with valid/bin/last sideband.
// Stage A squares each part, stage B sums and keeps the top POWER_WIDTH bits.
module fft_bin_power
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = BIN_DATA_WIDTH,
    parameter int POWER_WIDTH = BIN_POWER_WIDTH,
    parameter int BIN_WIDTH   = BIN_IDX_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    input  logic                          last_i,
    input  logic [BIN_WIDTH-1:0]          bin_i,
    input  logic signed [DATA_WIDTH-1:0]  real_i,
    input  logic signed [DATA_WIDTH-1:0]  imag_i,
    output logic                          valid_o,
    output logic                          last_o,
    output logic [BIN_WIDTH-1:0]          bin_o,
    output logic [POWER_WIDTH-1:0]        power_o
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int DROP   = PROD_W - POWER_WIDTH;

    logic signed [PROD_W-1:0] re_x;
    logic signed [PROD_W-1:0] im_x;
    logic [PROD_W-1:0]        re_sq;
    logic [PROD_W-1:0]        im_sq;
    logic                     sq_valid;
    logic                     sq_last;
    logic [BIN_WIDTH-1:0]     sq_bin;

    // Sign-extend so the square is exact; it is always non-negative.
    assign re_x = PROD_W'(real_i);
    assign im_x = PROD_W'(imag_i);

    // Stage A: square real and imaginary parts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_valid <= 1'b0;
            sq_last  <= 1'b0;
            sq_bin   <= '0;
            re_sq    <= '0;
            im_sq    <= '0;
        end else begin
            sq_valid <= valid_i;
            sq_last  <= valid_i && last_i;
            sq_bin   <= bin_i;
            re_sq    <= $unsigned(re_x * re_x);
            im_sq    <= $unsigned(im_x * im_x);
        end
    end

    // Stage B: sum (max 2^47, no overflow) and truncate LSBs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            bin_o   <= '0;
            power_o <= '0;
        end else begin
            valid_o <= sq_valid;
            last_o  <= sq_valid && sq_last;
            bin_o   <= sq_bin;
            power_o <= POWER_WIDTH'((re_sq + im_sq) >> DROP);
        end
    end

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over FFT bins MIN_BIN..FFT_SIZE/2-1.
// Build option: SPECTRUM_AVG_EN searches an IIR-averaged spectrum instead.
module fft_peak_detector
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = BIN_DATA_WIDTH,
    parameter int FFT_SIZE    = FFT_POINTS,
    parameter int POWER_WIDTH = BIN_POWER_WIDTH,
    parameter int MIN_BIN     = 1,
    parameter int AVG_SHIFT   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic signed [DATA_WIDTH-1:0] data_real_i,
    input  logic signed [DATA_WIDTH-1:0] data_imag_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [$clog2(FFT_SIZE)-1:0] peak_bin_o,
    output logic [POWER_WIDTH-1:0]      peak_power_o,
    output logic [15:0]                 frame_count_o,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic                        busy_o
);

    localparam int BIN_W = $clog2(FFT_SIZE);
    localparam int HALF  = FFT_SIZE / 2;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);
    localparam logic [BIN_W-1:0] HALF_IDX = BIN_W'(HALF);
    localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(MIN_BIN);

    peak_state_t state;

    logic [BIN_W-1:0] bin_cnt;
    logic             accept;
    logic             handshake;

    logic                         s1_valid;
    logic                         s1_last;
    logic [BIN_W-1:0]             s1_bin;
    logic signed [DATA_WIDTH-1:0] s1_re;
    logic signed [DATA_WIDTH-1:0] s1_im;

    logic                   pw_valid;
    logic                   pw_last;
    logic [BIN_W-1:0]       pw_bin;
    logic [POWER_WIDTH-1:0] pw_power;

    logic                   cmp_valid;
    logic                   cmp_last;
    logic [BIN_W-1:0]       cmp_bin;
    logic [POWER_WIDTH-1:0] cmp_power;
    logic                   cmp_search;

    logic                   done;
    logic [BIN_W-1:0]       peak_bin;
    logic [POWER_WIDTH-1:0] peak_power;

    assign accept    = valid_i && ready_o;
    assign handshake = result_valid_o && result_ready_i;

    // S1: capture accepted beat with its bin index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_bin   <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept && (bin_cnt == LAST_BIN);
            s1_bin   <= bin_cnt;
            s1_re    <= data_real_i;
            s1_im    <= data_imag_i;
        end
    end

    fft_bin_power #(
        .DATA_WIDTH  (DATA_WIDTH),
        .POWER_WIDTH (POWER_WIDTH),
        .BIN_WIDTH   (BIN_W)
    ) u_power (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (s1_valid),
        .last_i  (s1_last),
        .bin_i   (s1_bin),
        .real_i  (s1_re),
        .imag_i  (s1_im),
        .valid_o (pw_valid),
        .last_o  (pw_last),
        .bin_o   (pw_bin),
        .power_o (pw_power)
    );

`ifdef SPECTRUM_AVG_EN
    logic [POWER_WIDTH-1:0] avg_mem [HALF];
    logic [POWER_WIDTH-1:0] avg_old;
    logic [POWER_WIDTH-1:0] avg_new;
    logic signed [POWER_WIDTH:0] avg_diff;
    logic signed [POWER_WIDTH:0] avg_sum;
    logic                   pw_search;

    logic                   av_valid;
    logic                   av_last;
    logic [BIN_W-1:0]       av_bin;
    logic [POWER_WIDTH-1:0] av_power;

    assign pw_search = (pw_bin >= MIN_IDX) && (pw_bin < HALF_IDX);
    assign avg_old   = avg_mem[pw_bin[BIN_W-2:0]];

    // avg += (p - avg) >>> AVG_SHIFT in signed POWER_WIDTH+1 arithmetic.
    always_comb begin
        avg_diff = $signed({1'b0, pw_power}) - $signed({1'b0, avg_old});
        avg_sum  = $signed({1'b0, avg_old}) + (avg_diff >>> AVG_SHIFT);
        avg_new  = POWER_WIDTH'(avg_sum);
    end

    // Averaging stage: write back the new average and forward it to the search.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < HALF; i++) begin
                avg_mem[i] <= '0;
            end
            av_valid <= 1'b0;
            av_last  <= 1'b0;
            av_bin   <= '0;
            av_power <= '0;
        end else begin
            av_valid <= pw_valid;
            av_last  <= pw_valid && pw_last;
            av_bin   <= pw_bin;
            av_power <= avg_new;
            if (pw_valid && pw_search) begin
                avg_mem[pw_bin[BIN_W-2:0]] <= avg_new;
            end
        end
    end

    assign cmp_valid = av_valid;
    assign cmp_last  = av_last;
    assign cmp_bin   = av_bin;
    assign cmp_power = av_power;
`else
    assign cmp_valid = pw_valid;
    assign cmp_last  = pw_last;
    assign cmp_bin   = pw_bin;
    assign cmp_power = pw_power;
`endif

    assign cmp_search = (cmp_bin >= MIN_IDX) && (cmp_bin < HALF_IDX);

    // Comparator: strict greater-than so ties keep the lowest bin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done       <= 1'b0;
            peak_bin   <= MIN_IDX;
            peak_power <= '0;
        end else begin
            done <= cmp_valid && cmp_last;
            if (handshake) begin
                peak_bin   <= MIN_IDX;
                peak_power <= '0;
            end else if (cmp_valid && cmp_search && (cmp_power > peak_power)) begin
                peak_bin   <= cmp_bin;
                peak_power <= cmp_power;
            end
        end
    end

    // Frame FSM: collect bins, drain the pipeline, hold result until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_COLLECT;
            bin_cnt        <= '0;
            ready_o        <= 1'b0;
            result_valid_o <= 1'b0;
            peak_bin_o     <= '0;
            peak_power_o   <= '0;
            frame_count_o  <= '0;
            busy_o         <= 1'b0;
        end else begin
            unique case (state)
                ST_COLLECT: begin
                    ready_o <= 1'b1;
                    if (accept) begin
                        busy_o  <= 1'b1;
                        bin_cnt <= bin_cnt + 1'b1;
                        if (bin_cnt == LAST_BIN) begin
                            ready_o <= 1'b0;
                            state   <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (done) begin
                        result_valid_o <= 1'b1;
                        peak_bin_o     <= peak_bin;
                        peak_power_o   <= peak_power;
                        state          <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        frame_count_o  <= frame_count_o + 16'd1;
                        busy_o         <= 1'b0;
                        ready_o        <= 1'b1;
                        state          <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed self-checking bench for fft_peak_detector.
// With SPECTRUM_AVG_EN defined it exercises the averaging build instead.
module tb_fft_peak_detector;
    import fft_pkg::*;

`ifdef SPECTRUM_AVG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [23:0] re;
    logic signed [23:0] im;
    logic              valid;
    logic              ready;
    bin_idx_t          pbin;
    logic [31:0]       ppow;
    logic [15:0]       fcnt;
    logic              rv;
    logic              rr;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    logic signed [23:0] fr_re [256];
    logic signed [23:0] fr_im [256];

    always #5 clk = ~clk;

    fft_peak_detector #(
        .DATA_WIDTH  (24),
        .FFT_SIZE    (256),
        .POWER_WIDTH (32),
        .MIN_BIN     (1),
        .AVG_SHIFT   (1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_real_i    (re),
        .data_imag_i    (im),
        .valid_i        (valid),
        .ready_o        (ready),
        .peak_bin_o     (pbin),
        .peak_power_o   (ppow),
        .frame_count_o  (fcnt),
        .result_valid_o (rv),
        .result_ready_i (rr),
        .busy_o         (busy)
    );

    task automatic clear_frame();
        for (int i = 0; i < 256; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        rr    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive nbins beats; returns just after the edge accepting the last one.
    task automatic send_frame(input int nbins, input bit gaps);
        for (int k = 0; k < nbins; k++) begin
            bit acc = 1'b0;
            int guard = 0;
            while (!acc && guard < 64) begin
                bit r;
                @(negedge clk);
                if (gaps && $urandom_range(0, 2) == 0) begin
                    valid = 1'b0;
                end else begin
                    valid = 1'b1;
                    re = fr_re[k];
                    im = fr_im[k];
                end
                r = ready;
                @(posedge clk);
                acc = valid && r;
                guard++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: bin %0d never accepted, ready=%b", k, ready);
                @(negedge clk);
                valid = 1'b0;
                return;
            end
        end
    endtask

    // Counts edges after the last accepting edge until result_valid is seen.
    task automatic wait_result(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            valid = 1'b0;
            if (rv) break;
            @(posedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        rr    = 1'b0;
        re    = '0;
        im    = '0;
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        vectors++;
        if ({rv, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: got rv=%b busy=%b expected 0 0", rv, busy);
        end
        vectors++;
        if ({pbin, ppow, fcnt} !== 56'd0) begin
            miscompares++;
            $display("FAIL reset_data: got bin=%0d pow=%h cnt=%0d expected 0", pbin, ppow, fcnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_pre_edge: got %b expected 0", ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_rise: got %b expected 1", ready);
        end
    endtask

`ifndef SPECTRUM_AVG_EN
    task automatic test_tone();
        int n;
        clear_frame();
        fr_re[10] = 24'h400000;
        send_frame(256, 1'b0);
        wait_result(n);
        vectors++;
        if (n !== LAT) begin
            miscompares++;
            $display("FAIL tone_latency: got %0d edges expected %0d", n, LAT);
        end
        vectors++;
        if (pbin !== 8'd10) begin
            miscompares++;
            $display("FAIL tone_bin: got %0d expected 10", pbin);
        end
        vectors++;
        if (ppow !== 32'h1000_0000) begin
            miscompares++;
            $display("FAIL tone_power: got %h expected 10000000", ppow);
        end
        vectors++;
        if ({busy, ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL tone_busy_ready: got busy=%b ready=%b expected 1 0", busy, ready);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        vectors++;
        if ({rv, busy, ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL tone_handshake: got rv=%b busy=%b ready=%b expected 0 0 1", rv, busy, ready);
        end
        vectors++;
        if (fcnt !== 16'd1) begin
            miscompares++;
            $display("FAIL tone_count: got %0d expected 1", fcnt);
        end
    endtask

    task automatic test_rejection();
        int n;
        clear_frame();
        fr_re[0]   = 24'h7FFFFF;
        fr_re[250] = 24'h7FFFFF;
        fr_re[5]   = 24'h000100;
        send_frame(256, 1'b0);
        wait_result(n);
        vectors++;
        if ({pbin, ppow} !== {8'd5, 32'd1}) begin
            miscompares++;
            $display("FAIL reject_result: got bin=%0d pow=%h expected bin=5 pow=1", pbin, ppow);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        vectors++;
        if (fcnt !== 16'd2) begin
            miscompares++;
            $display("FAIL reject_count: got %0d expected 2", fcnt);
        end
    endtask

    task automatic test_tie();
        int n;
        clear_frame();
        fr_re[20] = 24'h200000;
        fr_re[40] = 24'h200000;
        send_frame(256, 1'b0);
        wait_result(n);
        vectors++;
        if ({pbin, ppow} !== {8'd20, 32'h0400_0000}) begin
            miscompares++;
            $display("FAIL tie_result: got bin=%0d pow=%h expected bin=20 pow=04000000", pbin, ppow);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
    endtask

    task automatic test_back_pressure();
        int n;
        do_reset();
        clear_frame();
        fr_re[100] = 24'h010000;
        fr_re[60]  = 24'h00C000;
        fr_im[3]   = -24'sh000800;
        send_frame(256, 1'b1);
        wait_result(n);
        vectors++;
        if (n !== LAT) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d edges expected %0d", n, LAT);
        end
        vectors++;
        if (fcnt !== 16'd0) begin
            miscompares++;
            $display("FAIL bp_count_before: got %0d expected 0", fcnt);
        end
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({rv, ready, pbin, ppow} !== {1'b1, 1'b0, 8'd100, 32'h0001_0000}) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got rv=%b ready=%b bin=%0d pow=%h expected 1 0 100 00010000",
                         c, rv, ready, pbin, ppow);
            end
            @(negedge clk);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        vectors++;
        if ({rv, fcnt} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL bp_handshake: got rv=%b cnt=%0d expected 0 1", rv, fcnt);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        clear_frame();
        fr_re[50] = 24'h7FFFFF;
        send_frame(100, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        vectors++;
        if ({ready, rv, busy, pbin, ppow, fcnt} !== 59'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ready=%b rv=%b busy=%b bin=%0d pow=%h cnt=%0d expected 0",
                     ready, rv, busy, pbin, ppow, fcnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_frame();
        fr_re[7] = 24'h400000;
        send_frame(256, 1'b0);
        wait_result(n);
        vectors++;
        if ({pbin, ppow} !== {8'd7, 32'h1000_0000}) begin
            miscompares++;
            $display("FAIL midreset_result: got bin=%0d pow=%h expected bin=7 pow=10000000", pbin, ppow);
        end
        vectors++;
        if (n !== LAT) begin
            miscompares++;
            $display("FAIL midreset_latency: got %0d edges expected %0d", n, LAT);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        vectors++;
        if (fcnt !== 16'd1) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d expected 1", fcnt);
        end
    endtask
`else
    task automatic test_avg();
        int n;
        do_reset();
        clear_frame();
        fr_re[10] = 24'h400000;
        send_frame(256, 1'b0);
        wait_result(n);
        vectors++;
        if (n !== LAT) begin
            miscompares++;
            $display("FAIL avg_latency: got %0d edges expected %0d", n, LAT);
        end
        vectors++;
        if ({pbin, ppow} !== {8'd10, 32'h0800_0000}) begin
            miscompares++;
            $display("FAIL avg_frame1: got bin=%0d pow=%h expected bin=10 pow=08000000", pbin, ppow);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        vectors++;
        if (fcnt !== 16'd1) begin
            miscompares++;
            $display("FAIL avg_count: got %0d expected 1", fcnt);
        end
        clear_frame();
        send_frame(256, 1'b0);
        wait_result(n);
        vectors++;
        if ({pbin, ppow} !== {8'd10, 32'h0400_0000}) begin
            miscompares++;
            $display("FAIL avg_frame2: got bin=%0d pow=%h expected bin=10 pow=04000000", pbin, ppow);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        vectors++;
        if (fcnt !== 16'd2) begin
            miscompares++;
            $display("FAIL avg_count2: got %0d expected 2", fcnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        rr    = 1'b0;
        re    = '0;
        im    = '0;
        test_reset();
`ifndef SPECTRUM_AVG_EN
        test_tone();
        test_rejection();
        test_tie();
        test_back_pressure();
        test_reset_midframe();
`else
        test_avg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
